// File: rtl/bw_io_cmos_rx_filt.sv
// Receive-side conditioner for a CMOS2 pad: synchronises to_core, rejects glitches, emits rise/fall pulses.
// Optional edge counter (edge_cnt_clr / edge_cnt) is built when BW_IO_RX_EDGE_CNT_EN is defined.
module bw_io_cmos_rx_filt #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter bit          RST_VAL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              to_core,
  input  logic              filt_en,
  input  logic [FILT_W-1:0] filt_len,
`ifdef BW_IO_RX_EDGE_CNT_EN
  input  logic              edge_cnt_clr,
  output logic [7:0]        edge_cnt,
`endif
  output logic              data_out,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              pend
);

  localparam int unsigned EDGE_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_LO   = 2'b00,
    PEND_HI = 2'b01,
    ST_HI   = 2'b11,
    PEND_LO = 2'b10
  } state_e;

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  state_e                 state_q;
  logic [FILT_W-1:0]      cnt_q;
  logic                   data_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   pend_q;
  logic                   mis_c;
  logic                   in_pend_c;
  logic                   accept_c;

  // Plain flop chain; nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], to_core};
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // A mismatch is accepted once it has persisted filt_len cycles past the first, or at once in bypass.
  always_comb begin
    mis_c     = (sync_q != data_q);
    in_pend_c = (state_q == PEND_HI) || (state_q == PEND_LO);
    accept_c  = 1'b0;
    if (mis_c) begin
      if (!filt_en) begin
        accept_c = 1'b1;
      end else if (in_pend_c) begin
        accept_c = (cnt_q >= filt_len);
      end else begin
        accept_c = (filt_len == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_VAL ? ST_HI : ST_LO;
      cnt_q   <= '0;
      data_q  <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (accept_c) begin
        data_q  <= sync_q;
        rise_q  <= sync_q;
        fall_q  <= ~sync_q;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        state_q <= sync_q ? ST_HI : ST_LO;
      end else if (mis_c && !in_pend_c) begin
        cnt_q   <= FILT_W'(1);
        pend_q  <= 1'b1;
        state_q <= data_q ? PEND_LO : PEND_HI;
      end else if (mis_c) begin
        cnt_q <= cnt_q + FILT_W'(1);
      end else if (in_pend_c) begin
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        state_q <= data_q ? ST_HI : ST_LO;
      end
    end
  end

  assign data_out   = data_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign pend       = pend_q;

`ifdef BW_IO_RX_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] edge_cnt_q;

  // Saturating count of emitted pulses; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
    end else if (edge_cnt_clr) begin
      edge_cnt_q <= '0;
    end else if ((rise_q || fall_q) && (edge_cnt_q != {EDGE_CNT_W{1'b1}})) begin
      edge_cnt_q <= edge_cnt_q + EDGE_CNT_W'(1);
    end
  end

  assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: tb/tb_bw_io_cmos_rx_filt.sv
// Randomised and directed bench for bw_io_cmos_rx_filt against a run-length reference model.
module tb_bw_io_cmos_rx_filt;
  localparam int unsigned S  = 2;
  localparam int unsigned FW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tc  = 1'b0;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic [FW-1:0] len = '0;
  logic          dout, rise, fall, pend;
`ifdef BW_IO_RX_EDGE_CNT_EN
  logic [7:0]    ecnt;
`endif

  always #5 clk = ~clk;

  bw_io_cmos_rx_filt #(.SYNC_STAGES(S), .FILT_W(FW), .RST_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .to_core(tc), .filt_en(en), .filt_len(len),
`ifdef BW_IO_RX_EDGE_CNT_EN
    .edge_cnt_clr(clr), .edge_cnt(ecnt),
`endif
    .data_out(dout), .rise_pulse(rise), .fall_pulse(fall), .pend(pend)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: delay line for the synchroniser, level plus length of current mismatch run.
  bit m_sync[$];
  bit m_level, m_rise, m_fall, m_pend;
  int m_run, m_ecnt;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = {};
    repeat (S) m_sync.push_back(1'b0);
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_pend = 1'b0;
    m_run = 0; m_ecnt = 0;
  endtask

  task automatic model_step();
    bit s;
    s = m_sync[0];
    if (clr) m_ecnt = 0;
    else if ((m_rise || m_fall) && m_ecnt < 255) m_ecnt++;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (!en || m_run >= int'(len) + 1) begin
        m_level = s;
        m_rise  = s;
        m_fall  = !s;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_pend = (m_run != 0);
    void'(m_sync.pop_front());
    m_sync.push_back(tc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("data_out", 32'(dout), int'(m_level));
    chk("rise_pulse", 32'(rise), int'(m_rise));
    chk("fall_pulse", 32'(fall), int'(m_fall));
    chk("pend", 32'(pend), int'(m_pend));
`ifdef BW_IO_RX_EDGE_CNT_EN
    chk("edge_cnt", 32'(ecnt), m_ecnt);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_data_out", 32'(dout), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_pulses", 32'({rise, fall}), 0);
`ifdef BW_IO_RX_EDGE_CNT_EN
    chk("rst_edge_cnt", 32'(ecnt), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Edge index (from the edge after which the input changed) of the first wanted pulse.
  task automatic measure(input string tag, input bit want_rise, input int exp_edge, input int n);
    int first;
    first = -1;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (first < 0 && (want_rise ? rise : fall) === 1'b1) first = e;
    end
    chk(tag, 32'(first), exp_edge);
  endtask

  initial begin
    int run_left;
    bit saw_pend, saw_rise;
    model_reset();

    // Reset values, then bypass with input high: data_out at edge 3.
    tc = 1'b1; en = 1'b0; len = '0;
    do_reset();
    tick(); chk("t1_e1", 32'(dout), 0);
    tick(); chk("t1_e2", 32'(dout), 0);
    tick(); chk("t1_e3", 32'(dout), 1); chk("t1_rise_e3", 32'(rise), 1);
    tick(); chk("t1_rise_e4", 32'(rise), 0);

    // Filter length 3: both transitions appear 6 edges after the input step.
    en = 1'b1; len = FW'(3); tc = 1'b0;
    measure("t3_fall_edge", 1'b0, 6, 10);
    tc = 1'b1;
    measure("t3_rise_edge", 1'b1, 6, 10);

    // Two-cycle glitch is rejected while pend is seen.
    tc = 1'b0;
    repeat (10) tick();
    saw_pend = 1'b0; saw_rise = 1'b0;
    tc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) tc = 1'b0;
      tick();
      if (pend === 1'b1) saw_pend = 1'b1;
      if (rise === 1'b1) saw_rise = 1'b1;
    end
    chk("t2_saw_pend", 32'(saw_pend), 1);
    chk("t2_saw_rise", 32'(saw_rise), 0);
    chk("t2_data_out", 32'(dout), 0);

    // Lowering filt_len mid-pend accepts on the next mismatch cycle.
    len = FW'(7); tc = 1'b1;
    repeat (5) tick();
    chk("t4_e5_data", 32'(dout), 0);
    chk("t4_e5_pend", 32'(pend), 1);
    len = FW'(2);
    tick();
    chk("t4_e6_data", 32'(dout), 1);
    chk("t4_e6_rise", 32'(rise), 1);

    // Reset during pend discards it; requalification starts over.
    tc = 1'b0; len = FW'(3);
    repeat (12) tick();
    tc = 1'b1;
    repeat (3) tick();
    chk("t5_pend", 32'(pend), 1);
    do_reset();
    measure("t5_requal_edge", 1'b1, 6, 10);

`ifdef BW_IO_RX_EDGE_CNT_EN
    // Saturation after 300 edges, then clear beats a simultaneous increment.
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tc = ~tc;
      repeat (4) tick();
    end
    chk("t6_sat", 32'(ecnt), 255);
    tc = ~tc;
    repeat (3) tick();
    chk("t6_pulse", 32'(rise | fall), 1);
    clr = 1'b1;
    tick();
    chk("t6_clr", 32'(ecnt), 0);
    clr = 1'b0;
`endif

    // Random input runs, filter settings, clears and occasional resets.
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        tc = ~tc;
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      if ($urandom_range(0, 15) == 0) len = FW'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) en = ~en;
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
